// File: rtl/spmv_mem_model.sv
// Main-memory response model for the SpMV PE: fixed-latency loads, stores, and
// strictly ordered responses through a stall-aware FIFO with request-side skid.
module spmv_mem_model #(
  parameter int unsigned LATENCY     = 200,
  parameter int unsigned ADDR_WIDTH  = 48,
  parameter int unsigned TAG_WIDTH   = 3,
  parameter int unsigned DEPTH_WORDS = 1048576,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned SKID        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_ld,
  input  logic                  req_st,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [63:0]           req_d_or_tag,
  output logic                  req_stall,
  output logic                  rsp_push,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic [63:0]           rsp_q,
  input  logic                  rsp_stall,
  output logic                  err
);
  localparam int unsigned IDX_W     = ADDR_WIDTH - 3;
  localparam int unsigned MEM_AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned DL_STAGES = LATENCY - 1;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned OUT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned STALL_THR = FIFO_DEPTH - SKID;

  logic [63:0]          mem [DEPTH_WORDS];
  logic [IDX_W-1:0]     idx;
  logic [MEM_AW-1:0]    mem_idx;
  logic                 in_range;
  logic [63:0]          ld_data;
  logic                 ld_acc;
  logic                 ld_drop_full;
  logic                 pop;
  logic                 fifo_wr;
  logic                 fifo_empty;
  logic                 unused_addr_lsb;

  logic [DL_STAGES-1:0] dl_vld;
  logic [TAG_WIDTH-1:0] dl_tag  [DL_STAGES];
  logic [63:0]          dl_data [DL_STAGES];

  logic [TAG_WIDTH-1:0] fifo_tag  [FIFO_DEPTH];
  logic [63:0]          fifo_data [FIFO_DEPTH];
  logic [PTR_W:0]       wr_ptr;
  logic [PTR_W:0]       rd_ptr;
  logic [OUT_W-1:0]     outstanding;

  assign idx             = req_addr[ADDR_WIDTH-1:3];
  assign mem_idx         = idx[MEM_AW-1:0];
  assign in_range        = 64'(idx) < 64'(DEPTH_WORDS);
  assign ld_data         = in_range ? mem[mem_idx] : 64'd0;
  assign unused_addr_lsb = ^req_addr[2:0];

  // Load wins a slot only when alone and the outstanding budget has room.
  assign ld_drop_full = req_ld && !req_st && (outstanding == OUT_W'(FIFO_DEPTH));
  assign ld_acc       = req_ld && !req_st && !ld_drop_full && !rst;
  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign pop          = !fifo_empty && !rsp_stall;
  assign fifo_wr      = dl_vld[DL_STAGES-1];

  // Backing store: no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && req_st && in_range) begin
      mem[mem_idx] <= req_d_or_tag;
    end
  end

  // The FIFO write counts as the final latency stage, so the line is LATENCY-1 deep.
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_vld <= '0;
    end else begin
      dl_vld[0] <= ld_acc;
      for (int i = 1; i < DL_STAGES; i++) begin
        dl_vld[i] <= dl_vld[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    dl_tag[0]  <= req_d_or_tag[TAG_WIDTH-1:0];
    dl_data[0] <= ld_data;
    for (int i = 1; i < DL_STAGES; i++) begin
      dl_tag[i]  <= dl_tag[i-1];
      dl_data[i] <= dl_data[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_tag[wr_ptr[PTR_W-1:0]]  <= dl_tag[DL_STAGES-1];
      fifo_data[wr_ptr[PTR_W-1:0]] <= dl_data[DL_STAGES-1];
    end
  end

  // Pointers, outstanding count, registered response and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      req_stall   <= 1'b0;
      rsp_push    <= 1'b0;
      rsp_tag     <= '0;
      rsp_q       <= '0;
      err         <= 1'b0;
    end else begin
      if (fifo_wr) begin
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      end
      rsp_push <= pop;
      if (pop) begin
        rd_ptr  <= rd_ptr + (PTR_W+1)'(1);
        rsp_tag <= fifo_tag[rd_ptr[PTR_W-1:0]];
        rsp_q   <= fifo_data[rd_ptr[PTR_W-1:0]];
      end
      if (ld_acc && !pop) begin
        outstanding <= outstanding + OUT_W'(1);
      end else if (!ld_acc && pop) begin
        outstanding <= outstanding - OUT_W'(1);
      end
      req_stall <= (outstanding >= OUT_W'(STALL_THR));
      if ((req_ld && req_st) || ((req_ld || req_st) && !in_range) || ld_drop_full) begin
        err <= 1'b1;
      end
    end
  end
endmodule
